// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default baud divider and the TX-FIFO launch FSM states.
package uart_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned CLKS_PER_BIT = 217;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port byte array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  i_clk,
   input  logic                  i_wr_en,
   input  logic [DEPTH_LOG2-1:0] i_wr_addr,
   input  logic [BYTE_W-1:0]     i_wr_data,
   input  logic [DEPTH_LOG2-1:0] i_rd_addr,
   output logic [BYTE_W-1:0]     o_rd_data
);

   logic [BYTE_W-1:0] r_mem [2**DEPTH_LOG2];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter, one launch per i_TX_Done handshake.
// Optional sticky drop flag o_overflow is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_wr_en,
   input  logic [BYTE_W-1:0]     i_wr_byte,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_count,
   output logic                  o_TX_DV,
   output logic [BYTE_W-1:0]     o_TX_Byte,
   input  logic                  i_TX_Active,
   input  logic                  i_TX_Done
`ifdef UART_TX_FIFO_OVF_EN
   ,
   output logic                  o_overflow
`endif
);

   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   tx_state_t               r_state;
   tx_state_t               w_state_next;
   logic [DEPTH_LOG2-1:0]   r_wr_ptr;
   logic [DEPTH_LOG2-1:0]   r_rd_ptr;
   logic [DEPTH_LOG2:0]     r_count;
   logic [DEPTH_LOG2:0]     w_count_next;
   logic                    r_full;
   logic                    r_empty;
   logic [BYTE_W-1:0]       r_tx_byte;
   logic [BYTE_W-1:0]       w_rd_data;
   logic                    w_wr_accept;
   logic                    w_pop;

   // Full is sampled from the register, so a pop in the same cycle cannot rescue a write.
   assign w_wr_accept = i_wr_en && !r_full;

   uart_fifo_mem #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_mem (
      .i_clk     (i_clk),
      .i_wr_en   (w_wr_accept),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_wr_byte),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   always_comb begin
      w_count_next = r_count;
      if (w_wr_accept && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (!w_wr_accept && w_pop) begin
         w_count_next = r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_tx_byte <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_tx_byte <= w_rd_data;
         end
         r_count <= w_count_next;
         r_full  <= (w_count_next == FULL_CNT);
         r_empty <= (w_count_next == '0);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:      if (w_pop) w_state_next = LAUNCH;
         LAUNCH:    w_state_next = WAIT_DONE;
         WAIT_DONE: if (i_TX_Done) w_state_next = IDLE;
         default:   w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_pop   = (r_state == IDLE) && !r_empty && !i_TX_Active;
      o_TX_DV = (r_state == LAUNCH);
   end

   assign o_full    = r_full;
   assign o_empty   = r_empty;
   assign o_count   = r_count;
   assign o_TX_Byte = r_tx_byte;

`ifdef UART_TX_FIFO_OVF_EN
   logic r_overflow;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_overflow <= 1'b0;
      end else if (i_wr_en && r_full) begin
         r_overflow <= 1'b1;
      end
   end

   assign o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural transmitter and a queue-based reference.
module tb_uart_tx_fifo;
   import uart_pkg::*;

   localparam int unsigned DEPTH_LOG2 = 4;
   localparam int          DEPTH      = 16;

   logic                i_clk = 1'b0;
   logic                i_reset;
   logic                i_wr_en;
   logic [7:0]          i_wr_byte;
   logic                o_full;
   logic                o_empty;
   logic [DEPTH_LOG2:0] o_count;
   logic                o_TX_DV;
   logic [7:0]          o_TX_Byte;
   logic                i_TX_Active;
   logic                i_TX_Done;
`ifdef UART_TX_FIFO_OVF_EN
   logic                o_overflow;
`endif

   int         tests_run    = 0;
   int         tests_failed = 0;
   logic [7:0] launched[$];
   int         tx_len  = 4;
   bit         tx_hold = 1'b0;
   logic       tx_busy;

   assign i_TX_Active = tx_hold | tx_busy;

   uart_tx_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_wr_en     (i_wr_en),
      .i_wr_byte   (i_wr_byte),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_count     (o_count),
      .o_TX_DV     (o_TX_DV),
      .o_TX_Byte   (o_TX_Byte),
      .i_TX_Active (i_TX_Active),
      .i_TX_Done   (i_TX_Done)
`ifdef UART_TX_FIFO_OVF_EN
      ,
      .o_overflow  (o_overflow)
`endif
   );

   initial forever #5 i_clk = ~i_clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Transmitter model: busy for tx_len cycles after each launch, then a one-cycle done pulse.
   initial begin
      bit aborted;
      tx_busy   = 1'b0;
      i_TX_Done = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_TX_DV === 1'b1 && i_reset !== 1'b1) begin
            aborted = 1'b0;
            tx_busy = 1'b1;
            for (int k = 0; k < tx_len; k++) begin
               @(negedge i_clk);
               if (i_reset === 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
            end
            tx_busy = 1'b0;
            if (!aborted) begin
               i_TX_Done = 1'b1;
               @(negedge i_clk);
               i_TX_Done = 1'b0;
            end
         end
      end
   end

   initial forever begin
      @(negedge i_clk);
      if (o_TX_DV === 1'b1) launched.push_back(o_TX_Byte);
   end

   task automatic do_write(input logic [7:0] b);
      i_wr_en   = 1'b1;
      i_wr_byte = b;
      @(negedge i_clk);
      i_wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int n, input int budget, output bit ok);
      int c = 0;
      while ((launched.size() < n || tx_busy || !o_empty) && c < budget) begin
         @(posedge i_clk);
         #1;
         c++;
      end
      ok = (c < budget);
      repeat (4) @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic test_reset;
      i_reset   = 1'b1;
      i_wr_en   = 1'b0;
      i_wr_byte = 8'h00;
      repeat (3) @(negedge i_clk);
      tests_run++; if (o_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", o_empty); end
      tests_run++; if (o_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", o_full); end
      tests_run++; if (o_count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", o_count); end
      tests_run++; if (o_TX_DV !== 1'b0) begin tests_failed++; $display("FAIL reset_dv: got %b want 0", o_TX_DV); end
      tests_run++; if (o_TX_Byte !== 8'h00) begin tests_failed++; $display("FAIL reset_byte: got %h want 00", o_TX_Byte); end
`ifdef UART_TX_FIFO_OVF_EN
      tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
`endif
      i_reset = 1'b0;
      repeat (3) @(negedge i_clk);
      tests_run++; if (o_empty !== 1'b1 || o_TX_DV !== 1'b0) begin tests_failed++; $display("FAIL idle_after_reset: empty=%b dv=%b want 1/0", o_empty, o_TX_DV); end
   endtask

   task automatic test_single;
      bit ok;
      tx_len = 10 * CLKS_PER_BIT;
      launched.delete();
      @(negedge i_clk);
      do_write(8'h3F);
      tests_run++; if (o_count !== 5'd1 || o_TX_DV !== 1'b0) begin tests_failed++; $display("FAIL single_edgeN: count=%0d dv=%b want 1/0", o_count, o_TX_DV); end
      @(negedge i_clk);
      tests_run++; if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'h3F) begin tests_failed++; $display("FAIL single_latency: dv=%b byte=%h want 1/3f", o_TX_DV, o_TX_Byte); end
      tests_run++; if (o_count !== 5'd0) begin tests_failed++; $display("FAIL single_pop: count=%0d want 0", o_count); end
      @(negedge i_clk);
      tests_run++; if (o_TX_DV !== 1'b0 || o_TX_Byte !== 8'h3F) begin tests_failed++; $display("FAIL single_pulse: dv=%b byte=%h want 0/3f", o_TX_DV, o_TX_Byte); end
      wait_drain(1, 3000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_timeout: got %0d launches want 1", launched.size()); end
      tests_run++; if (launched.size() != 1 || launched[0] !== 8'h3F) begin tests_failed++; $display("FAIL single_seq: got %0d launches want exactly one of 3f", launched.size()); end
      tests_run++; if (o_TX_Byte !== 8'h3F) begin tests_failed++; $display("FAIL single_hold: byte=%h want 3f", o_TX_Byte); end
   endtask

   task automatic test_burst;
      bit ok;
      int peak = 0;
      tx_len = $urandom_range(5, 20);
      launched.delete();
      @(negedge i_clk);
      for (int i = 1; i <= 5; i++) begin
         do_write(8'(i));
         if (int'(o_count) > peak) peak = int'(o_count);
      end
      wait_drain(5, 1000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL burst_timeout: got %0d launches want 5", launched.size()); end
      tests_run++; if (peak < 4 || peak > 5) begin tests_failed++; $display("FAIL burst_peak: got %0d want 4..5", peak); end
      tests_run++; if (launched.size() != 5) begin tests_failed++; $display("FAIL burst_len: got %0d want 5", launched.size()); end
      for (int i = 0; i < 5 && i < launched.size(); i++) begin
         tests_run++; if (launched[i] !== 8'(i + 1)) begin tests_failed++; $display("FAIL burst_order[%0d]: got %h want %h", i, launched[i], 8'(i + 1)); end
      end
      tests_run++; if (o_count !== 5'd0) begin tests_failed++; $display("FAIL burst_end_count: got %0d want 0", o_count); end
   endtask

   task automatic test_full;
      bit ok;
      logic [7:0] exp[$];
      logic [7:0] b;
      launched.delete();
      tx_hold = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         exp.push_back(b);
         do_write(b);
      end
      tests_run++; if (o_full !== 1'b1 || o_count !== 5'd16) begin tests_failed++; $display("FAIL full_16: full=%b count=%0d want 1/16", o_full, o_count); end
`ifdef UART_TX_FIFO_OVF_EN
      tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_early: got %b want 0", o_overflow); end
`endif
      do_write(8'($urandom));
      tests_run++; if (o_full !== 1'b1 || o_count !== 5'd16) begin tests_failed++; $display("FAIL full_drop: full=%b count=%0d want 1/16", o_full, o_count); end
`ifdef UART_TX_FIFO_OVF_EN
      tests_run++; if (o_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
`endif
      tx_len  = $urandom_range(2, 10);
      tx_hold = 1'b0;
      wait_drain(DEPTH, 4000, ok);
      tests_run++; if (!ok || launched.size() != DEPTH) begin tests_failed++; $display("FAIL full_drain: got %0d launches want 16", launched.size()); end
      for (int i = 0; i < DEPTH && i < launched.size(); i++) begin
         tests_run++; if (launched[i] !== exp[i]) begin tests_failed++; $display("FAIL full_order[%0d]: got %h want %h", i, launched[i], exp[i]); end
      end
   endtask

   task automatic test_wrap;
      bit ok;
      logic [7:0] exp[$];
      logic [7:0] start;
      logic [7:0] b;
      int written = 0;
      int guard = 0;
      launched.delete();
      tx_len = $urandom_range(1, 6);
      start = 8'($urandom);
      while (written < 40 && guard < 4000) begin
         guard++;
         if ($urandom_range(0, 3) != 0 && o_full === 1'b0) begin
            b = start + 8'(written);
            exp.push_back(b);
            do_write(b);
            written++;
         end else begin
            @(negedge i_clk);
         end
      end
      wait_drain(40, 4000, ok);
      tests_run++; if (!ok || launched.size() != 40) begin tests_failed++; $display("FAIL wrap_len: got %0d launches want 40", launched.size()); end
      for (int i = 0; i < exp.size() && i < launched.size(); i++) begin
         tests_run++; if (launched[i] !== exp[i]) begin tests_failed++; $display("FAIL wrap_order[%0d]: got %h want %h", i, launched[i], exp[i]); end
      end
   endtask

   task automatic test_simultaneous;
      bit ok;
      logic [7:0] exp[$];
      logic [7:0] b;
      launched.delete();
      tx_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         exp.push_back(b);
         do_write(b);
      end
      tests_run++; if (o_count !== 5'd3) begin tests_failed++; $display("FAIL simul_pre: count=%0d want 3", o_count); end
      b = 8'($urandom);
      exp.push_back(b);
      tx_len  = $urandom_range(2, 8);
      tx_hold = 1'b0;
      do_write(b);
      tests_run++; if (o_count !== 5'd3) begin tests_failed++; $display("FAIL simul_count: got %0d want 3", o_count); end
      tests_run++; if (o_TX_DV !== 1'b1 || o_TX_Byte !== exp[0]) begin tests_failed++; $display("FAIL simul_launch: dv=%b byte=%h want 1/%h", o_TX_DV, o_TX_Byte, exp[0]); end
      wait_drain(4, 1000, ok);
      tests_run++; if (!ok || launched.size() != 4) begin tests_failed++; $display("FAIL simul_len: got %0d launches want 4", launched.size()); end
      for (int i = 0; i < 4 && i < launched.size(); i++) begin
         tests_run++; if (launched[i] !== exp[i]) begin tests_failed++; $display("FAIL simul_order[%0d]: got %h want %h", i, launched[i], exp[i]); end
      end
   endtask

   task automatic test_reset_midop;
      bit ok;
      launched.delete();
      tx_len  = 100;
      tx_hold = 1'b1;
      for (int i = 0; i < 6; i++) do_write(8'hA0 + 8'(i));
      tx_hold = 1'b0;
      repeat (3) @(negedge i_clk);
      tests_run++; if (o_count !== 5'd5 || launched.size() != 1) begin tests_failed++; $display("FAIL midop_pre: count=%0d launches=%0d want 5/1", o_count, launched.size()); end
      @(posedge i_clk);
      #2 i_reset = 1'b1;
      #1;
      tests_run++; if (o_empty !== 1'b1 || o_count !== 5'd0) begin tests_failed++; $display("FAIL midop_async_empty: empty=%b count=%0d want 1/0", o_empty, o_count); end
      tests_run++; if (o_TX_DV !== 1'b0 || o_TX_Byte !== 8'h00) begin tests_failed++; $display("FAIL midop_async_tx: dv=%b byte=%h want 0/00", o_TX_DV, o_TX_Byte); end
`ifdef UART_TX_FIFO_OVF_EN
      tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL midop_ovf: got %b want 0", o_overflow); end
`endif
      repeat (2) @(negedge i_clk);
      i_reset = 1'b0;
      repeat (10) @(negedge i_clk);
      tests_run++; if (launched.size() != 1 || o_empty !== 1'b1) begin tests_failed++; $display("FAIL midop_no_launch: launches=%0d empty=%b want 1/1", launched.size(), o_empty); end
      tx_hold = 1'b1;
      do_write(8'h5A);
      repeat (10) @(negedge i_clk);
      tests_run++; if (launched.size() != 1 || o_count !== 5'd1) begin tests_failed++; $display("FAIL midop_wait_active: launches=%0d count=%0d want 1/1", launched.size(), o_count); end
      tx_len  = 4;
      tx_hold = 1'b0;
      wait_drain(2, 500, ok);
      tests_run++; if (!ok || launched.size() != 2 || launched[launched.size() - 1] !== 8'h5A) begin tests_failed++; $display("FAIL midop_relaunch: launches=%0d want 2 ending in 5a", launched.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_full();
      test_wrap();
      test_simultaneous();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
